// File: rtl/pipe_fetch_ctrl.sv
// IF-stage sequencer: PC register, imem req/ready handshake, IF/ID buffer with skid, delay-slot redirects.
// Optional perf counters are compiled in with `define PIPE_FETCH_PERF_EN.
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc4,
  output logic [31:0] pc,
  output logic        imem_timeout
`ifdef PIPE_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_WAIT_ID = 2'd2;
  localparam logic [15:0] LIMIT    = 16'(WAIT_LIMIT);

  logic [1:0]  state;
  logic [31:0] skid, skid_pc4, pend_pc;
  logic        pend;
  logic [15:0] wait_cnt;
  logic [16:0] cnt_inc;
  logic        consume, buf_free, accept, redirect;
  logic [31:0] target, pc_inc, next_pc;

  assign consume   = if_valid & ~id_stall;
  assign buf_free  = ~if_valid | ~id_stall;
  assign accept    = (state == S_FETCH) & imem_ready;
  assign redirect  = consume & (pcsrc != 2'd0);
  assign pc_inc    = pc + 32'd4;
  assign cnt_inc   = {1'b0, wait_cnt} + 17'd1;
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  always_comb begin
    target = pc_inc;
    case (pcsrc)
      2'd1:    target = bpc;
      2'd2:    target = rpc;
      2'd3:    target = jpc;
      default: target = pc_inc;
    endcase
  end

  // A latched redirect always wins: it belongs to the fetch completing now.
  assign next_pc = pend ? pend_pc : (redirect ? target : pc_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_ins   <= 32'h0;
      if_pc4   <= 32'h0;
      skid     <= 32'h0;
      skid_pc4 <= 32'h0;
      pend     <= 1'b0;
      pend_pc  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            pc   <= next_pc;
            pend <= 1'b0;
            if (buf_free) begin
              if_ins   <= imem_rdata;
              if_pc4   <= pc_inc;
              if_valid <= 1'b1;
            end else begin
              skid     <= imem_rdata;
              skid_pc4 <= pc_inc;
              state    <= S_WAIT_ID;
            end
          end else begin
            if (consume) if_valid <= 1'b0;
            // Delay slot still in flight: hold the target until it lands.
            if (redirect) begin
              pend    <= 1'b1;
              pend_pc <= target;
            end
          end
        end
        S_WAIT_ID: begin
          if (!id_stall) begin
            if_ins <= skid;
            if_pc4 <= skid_pc4;
            state  <= S_FETCH;
            if (redirect) pc <= target;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= 16'h0;
      imem_timeout <= 1'b0;
    end else if (accept) begin
      wait_cnt <= 16'h0;
    end else if (state == S_FETCH) begin
      if (wait_cnt != LIMIT) wait_cnt <= cnt_inc[15:0];
      if (cnt_inc >= {1'b0, LIMIT}) imem_timeout <= 1'b1;
    end
  end

`ifdef PIPE_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (accept) perf_fetched <= perf_fetched + 32'd1;
      if (if_valid & id_stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Directed bench for pipe_fetch_ctrl: vector table plus reset/timeout sequences.
module tb_pipe_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, rpc, jpc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ins, if_pc4, pc;
  logic        imem_timeout;
`ifdef PIPE_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [31:0] perf_snap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_fetch_ctrl #(.RESET_PC(32'h0), .WAIT_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ins(if_ins), .if_pc4(if_pc4), .pc(pc), .imem_timeout(imem_timeout)
`ifdef PIPE_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus legality: no second redirect while one is still pending.
  logic pend_m;
  always @(posedge clk or posedge rst) begin
    if (rst) pend_m <= 1'b0;
    else if (imem_req & imem_ready) pend_m <= 1'b0;
    else if (imem_req & if_valid & ~id_stall & (pcsrc != 2'd0)) begin
      assert (!pend_m) else $error("second redirect while pending");
      pend_m <= 1'b1;
    end
  end

  typedef struct {
    logic        stall;
    logic        ready;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] pc4;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic ready, input logic [1:0] src,
                       input logic [31:0] tgt, input logic [31:0] rdata);
    id_stall   = stall;
    imem_ready = ready;
    pcsrc      = src;
    imem_rdata = rdata;
    bpc = (src == 2'd1) ? tgt : 32'hDEAD_0001;
    rpc = (src == 2'd2) ? tgt : 32'hDEAD_0002;
    jpc = (src == 2'd3) ? tgt : 32'hDEAD_0003;
  endtask

  // Called just after a posedge with rst high: one IDLE cycle, then FETCH.
  task automatic release_reset(input string tag);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, " req idle"}, {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk({tag, " req fetch"}, {31'h0, imem_req}, 32'h1);
    chk({tag, " addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    //        stall rdy src tgt           rdata          req addr          vld ins            pc4
    vt[0]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hA000_0000, 1'b1, 32'h4,         1'b1, 32'hA000_0000, 32'h4};
    vt[1]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hA000_0004, 1'b1, 32'h8,         1'b1, 32'hA000_0004, 32'h8};
    vt[2]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hA000_0008, 1'b1, 32'hC,         1'b1, 32'hA000_0008, 32'hC};
    vt[3]  = '{1'b0, 1'b1, 2'd3, 32'h40,        32'hA000_000C, 1'b1, 32'h40,        1'b1, 32'hA000_000C, 32'h10};
    vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h40,        1'b0, 32'hA000_000C, 32'h10};
    vt[5]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hA000_0040, 1'b1, 32'h44,        1'b1, 32'hA000_0040, 32'h44};
    vt[6]  = '{1'b0, 1'b0, 2'd1, 32'h100,       32'h0,         1'b1, 32'h44,        1'b0, 32'hA000_0040, 32'h44};
    vt[7]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hA000_0044, 1'b1, 32'h100,       1'b1, 32'hA000_0044, 32'h48};
    vt[8]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'hA000_0100, 1'b0, 32'h104,       1'b1, 32'hA000_0044, 32'h48};
    vt[9]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'hBAD0_0000, 1'b0, 32'h104,       1'b1, 32'hA000_0044, 32'h48};
    vt[10] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b1, 32'hA000_0100, 32'h104};
    vt[11] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 32'h104,       1'b1, 32'hA000_0100, 32'h104};
    vt[12] = '{1'b0, 1'b1, 2'd0, 32'h0,         32'hA000_0104, 1'b1, 32'h108,       1'b1, 32'hA000_0104, 32'h108};
    vt[13] = '{1'b1, 1'b1, 2'd0, 32'h0,         32'hA000_0108, 1'b0, 32'h10C,       1'b1, 32'hA000_0104, 32'h108};
    vt[14] = '{1'b0, 1'b0, 2'd2, 32'h200,       32'h0,         1'b1, 32'h200,       1'b1, 32'hA000_0108, 32'h10C};
    vt[15] = '{1'b0, 1'b1, 2'd3, 32'hFFFF_FFFC, 32'hA000_0200, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hA000_0200, 32'h204};
    vt[16] = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h1234_5678, 1'b1, 32'h0,         1'b1, 32'h1234_5678, 32'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc", pc, 32'h0);
    chk("rst req", {31'h0, imem_req}, 32'h0);
    chk("rst vld", {31'h0, if_valid}, 32'h0);
    chk("rst ins", if_ins, 32'h0);
    chk("rst pc4", if_pc4, 32'h0);
    chk("rst timeout", {31'h0, imem_timeout}, 32'h0);
    release_reset("rel0");

    for (int i = 0; i < 17; i++) begin
`ifdef PIPE_FETCH_PERF_EN
      perf_snap = perf_fetched;
`endif
      drive(vt[i].stall, vt[i].ready, vt[i].src, vt[i].tgt, vt[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d req", i), {31'h0, imem_req}, {31'h0, vt[i].req});
      chk($sformatf("v%0d addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d pc", i), pc, vt[i].addr);
      chk($sformatf("v%0d vld", i), {31'h0, if_valid}, {31'h0, vt[i].vld});
      chk($sformatf("v%0d ins", i), if_ins, vt[i].ins);
      chk($sformatf("v%0d pc4", i), if_pc4, vt[i].pc4);
      chk($sformatf("v%0d timeout", i), {31'h0, imem_timeout}, 32'h0);
`ifdef PIPE_FETCH_PERF_EN
      if (i == 3) chk("perf_fetched delta", perf_fetched - perf_snap, 32'h1);
`endif
    end

    // Slow memory with WAIT_LIMIT=2: three wait cycles then completion.
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("slow w1 timeout", {31'h0, imem_timeout}, 32'h0);
    chk("slow w1 vld", {31'h0, if_valid}, 32'h0);
    @(negedge clk);
    chk("slow w2 timeout", {31'h0, imem_timeout}, 32'h1);
    @(negedge clk);
    chk("slow w3 timeout", {31'h0, imem_timeout}, 32'h1);
    chk("slow w3 req", {31'h0, imem_req}, 32'h1);
    chk("slow w3 addr", imem_addr, 32'h0);
    drive(1'b0, 1'b1, 2'd0, 32'h0, 32'hCAFE_0000);
    @(negedge clk);
    chk("slow done ins", if_ins, 32'hCAFE_0000);
    chk("slow done pc4", if_pc4, 32'h4);
    chk("slow done addr", imem_addr, 32'h4);
    chk("slow done timeout", {31'h0, imem_timeout}, 32'h1);

    // Reset in the middle of a waiting fetch; a late ready must be ignored.
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst pc", pc, 32'h0);
    chk("midrst req", {31'h0, imem_req}, 32'h0);
    chk("midrst vld", {31'h0, if_valid}, 32'h0);
    chk("midrst timeout", {31'h0, imem_timeout}, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk("midrst late vld", {31'h0, if_valid}, 32'h0);
    chk("midrst late ins", if_ins, 32'h0);
    imem_ready = 1'b0;
    release_reset("rel1");
    chk("midrst after vld", {31'h0, if_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_fetch_ctrl.md
Name: pipe_fetch_ctrl

Overview:
- IF-stage sequencer for the 5-stage pipeline.
- Owns the PC register and issues requests to a multi-cycle instruction memory over a req/ready handshake.
- Holds the IF/ID instruction buffer and sequences next-PC selection (pc+4 / branch / jr / j) with MIPS single delay-slot semantics.
- Honours ID-stage stalls and flags memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- WAIT_LIMIT, 255, FETCH wait cycles without imem_ready before imem_timeout sets (1..65535)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- pcsrc  in  2  next-PC select for the instruction in ID: 0 = pc+4, 1 = bpc, 2 = rpc, 3 = jpc
- bpc  in  32  branch target
- rpc  in  32  jr target
- jpc  in  32  j/jal target
- id_stall  in  1  ID cannot accept the buffered instruction this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  instruction word
- if_valid  out  1  IF/ID buffer holds an instruction
- if_ins  out  32  buffered instruction
- if_pc4  out  32  address of buffered instruction + 4
- pc  out  32  current fetch PC
- imem_timeout  out  1  sticky: WAIT_LIMIT reached

Behaviour:
- Reset (asynchronous, any state):
  - pc = RESET_PC; if_valid = 0; if_ins = 0; if_pc4 = 0; imem_req = 0; imem_timeout = 0.
  - skid and pending-redirect registers cleared; wait counter = 0; state = IDLE.
  - Any fetch in flight is abandoned; a late imem_ready after reset is ignored.
- States: IDLE, FETCH, WAIT_ID.
  - IDLE: imem_req = 0; unconditionally goes to FETCH next cycle.
  - FETCH: imem_req = 1, imem_addr = pc.
- Definitions:
  - consume = if_valid & ~id_stall.
  - buf_free = ~if_valid | ~id_stall.
  - accept = FETCH & imem_ready.
  - redirect = consume & (pcsrc != 0); target = mux(pcsrc).
- accept & buf_free:
  - if_ins <= imem_rdata; if_pc4 <= pc + 4; if_valid <= 1.
  - pc <= next_pc; stay in FETCH, so the next request is back-to-back.
- accept & ~buf_free: skid <= imem_rdata, skid_pc4 <= pc + 4, pc <= next_pc; go to WAIT_ID (imem_req = 0).
- WAIT_ID: when ~id_stall, buffer <= skid, if_valid stays 1, go to FETCH. Otherwise hold.
- consume with no load into the buffer this cycle: if_valid <= 0.
- next_pc is, in priority order:
  - pending target, if the pending flag is set (flag clears);
  - otherwise target, if redirect occurs in the same cycle;
  - otherwise pc + 4.
- Redirect timing (delay slot = word after the branch):
  - If redirect coincides with accept, or occurs in WAIT_ID→FETCH, the delay slot is already captured, so pc <= target directly.
  - Otherwise (delay slot still in flight), target is latched as pending and applied at that fetch's completion.
- A second redirect while pending is set cannot occur (the delay slot is not yet buffered). The bench asserts this.
- pc + 4 wraps modulo 2^32 (0xFFFF_FFFC → 0).
- Wait counter:
  - Increments each FETCH cycle with ~imem_ready; clears on accept.
  - When it reaches WAIT_LIMIT, imem_timeout <= 1 (sticky until rst). The fetch keeps waiting.
  - The counter saturates.
- imem_req deasserts only on accept, reset, or entry to WAIT_ID. It is never withdrawn mid-wait.

Optional Feature:
- Macro: PIPE_FETCH_PERF_EN.
- Defined:
  - Extra output ports perf_fetched[31:0] (+1 per accept) and perf_stall[31:0] (+1 per cycle with if_valid & id_stall).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset mid-fetch: rst asserted during FETCH with imem_ready=0 → pc=RESET_PC, imem_req=0, if_valid=0 immediately. imem_req=1 two cycles after rst falls.
- Zero-wait stream, id_stall=0, imem_ready=1 every cycle: imem_addr 0,4,8,C on consecutive cycles; if_ins follows one cycle later; if_pc4=4,8,C.
- Slow memory: 3 wait cycles per fetch, WAIT_LIMIT=2 → imem_timeout rises on the 2nd wait cycle, stays 1; fetch still completes.
- Stall with skid: if_valid=1, id_stall=1, accept of word at 0x8 → WAIT_ID, imem_req=0. Release stall → if_ins=word@0x8, fetch resumes at 0xC.
- Branch, delay slot in flight: branch consumed with pcsrc=1, bpc=0x100 while fetch of 0x8 is pending → 0x8 delivered, next imem_addr=0x100.
- Jump coinciding with accept: pcsrc=3, jpc=0x40, imem_ready=1 same cycle → next imem_addr=0x40. With PIPE_FETCH_PERF_EN, perf_fetched increments by 1.
